// File: rtl/as_imem_ctrl_pkg.sv
// as_pack: shared widths, controller state encoding, NOP constant and the
// scan-word layout used by the IMEM load controller.
package as_pack;

    localparam int imem_addr_width = 12;
    localparam int instr_width     = 32;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } imem_ctrl_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Scan word as delivered by the TAP data register; LSB is the write flag.
    typedef struct packed {
        logic [imem_addr_width-1:0] addr;
        logic [instr_width-1:0]     instr;
        logic                       we;
    } imem_scan_word_t;

    // Byte address is usable for a word write only when it is word aligned.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/as_imem_ctrl_if.sv
// as_imem_ctrl_if: scan handshake, core fetch port and IMEM port of the
// IMEM load controller. The controller side uses the slave modport.
interface as_imem_ctrl_if import as_pack::*; #(
    parameter int IMEM_AW = imem_addr_width,
    parameter int INSTR_W = instr_width
);
    logic                       scan_valid;
    logic                       scan_ready;
    logic [IMEM_AW+INSTR_W:0]   scan_word;

    logic                       core_req;
    logic [IMEM_AW-1:0]         core_addr;
    logic [INSTR_W-1:0]         core_instr;
    logic                       core_stall;

    logic [IMEM_AW-3:0]         imem_addr;
    logic [INSTR_W-1:0]         imem_wdata;
    logic                       imem_we;
    logic [INSTR_W-1:0]         imem_rdata;

    modport master (
        output scan_valid, scan_word, core_req, core_addr, imem_rdata,
        input  scan_ready, core_instr, core_stall, imem_addr, imem_wdata, imem_we
    );

    modport slave (
        input  scan_valid, scan_word, core_req, core_addr, imem_rdata,
        output scan_ready, core_instr, core_stall, imem_addr, imem_wdata, imem_we
    );
endinterface

// File: rtl/as_imem_scan_fifo.sv
// as_imem_scan_fifo: small synchronous FIFO for scan words. The head entry is
// visible combinationally so the controller can decide and pop in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module as_imem_scan_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]      count_reg, count_next;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] rd_data [DEPTH];

    assign full_o  = (count_reg == (PW+1)'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = rd_data[rd_ptr_reg];

    // Storage entries are not reset; the pointers define what is valid.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            // Capture the incoming word into the slot the write pointer selects.
            always_ff @(posedge clk_i) begin
                if (push_ok && (wr_ptr_reg == PW'(gi)))
                    entry_reg <= din_i;
            end
            assign rd_data[gi] = entry_reg;
        end
    endgenerate

    // Occupancy follows push/pop; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy state; reset flushes the buffer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/as_imem_ctrl.sv
// as_imem_ctrl: buffers JTAG scan words, loads them into the IMEM while the
// core is held in reset, then shares the single IMEM port between core fetch
// and late debug writes (writes win, the core is stalled for that cycle).
// Optional feature macro: AS_IMEM_WRCOUNT_EN enables the write counter and
// the sticky misaligned-write error flag; otherwise both outputs read 0.
module as_imem_ctrl import as_pack::*; #(
    parameter int IMEM_AW     = imem_addr_width,
    parameter int INSTR_W     = instr_width,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    as_imem_ctrl_if.slave  bus,
    output logic           core_rst_o,
    output logic           load_active_o,
    output logic           err_o,
    output logic [15:0]    wr_count_o
);
    localparam int SW_W = IMEM_AW + INSTR_W + 1;
    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] ST_LOAD    = LOAD;
    localparam logic [1:0] ST_RELEASE = RELEASE;
    localparam logic [1:0] ST_RUN     = RUN;

    localparam logic [HC_W-1:0]    HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [INSTR_W-1:0] NOP_W     = INSTR_W'(NOP_INSTR);

    logic [1:0]         state_reg, state_next;
    logic [HC_W-1:0]    hold_cnt_reg, hold_cnt_next;

    logic [SW_W-1:0]    head_word;
    logic [IMEM_AW-1:0] head_addr;
    logic [INSTR_W-1:0] head_instr;
    logic               head_we;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               wr_fire, misaligned_drop, release_pop, in_run;

    assign head_we    = head_word[0];
    assign head_instr = head_word[INSTR_W:1];
    assign head_addr  = head_word[SW_W-1 -: IMEM_AW];

    assign bus.scan_ready = !fifo_full;

    // The head is consumed every cycle except while the release hold runs.
    assign fifo_pop        = !fifo_empty && (state_reg != ST_RELEASE);
    assign wr_fire         = fifo_pop && head_we && is_word_aligned(head_addr[1:0]);
    assign misaligned_drop = fifo_pop && head_we && !is_word_aligned(head_addr[1:0]);
    assign release_pop     = fifo_pop && !head_we && (state_reg == ST_LOAD);
    assign in_run          = (state_reg == ST_RUN);

    as_imem_scan_fifo #(
        .WIDTH (SW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_scan_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus.scan_valid),
        .din_i   (bus.scan_word),
        .pop_i   (fifo_pop),
        .dout_o  (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Load/release/run sequencing. The hold counter reaches 0 on the same edge
    // that enters RUN, so core reset drops exactly HOLD_CYCLES after the pop.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_LOAD: begin
                if (release_pop) begin
                    hold_cnt_next = HOLD_LOAD;
                    state_next    = (HOLD_CYCLES == 1) ? ST_RUN : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (hold_cnt_reg != '0)
                    hold_cnt_next = hold_cnt_reg - 1'b1;
                if (hold_cnt_reg <= HC_W'(1))
                    state_next = ST_RUN;
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_LOAD;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= ST_LOAD;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Port arbitration: a head write owns the port; otherwise the core does in RUN.
    always_comb begin
        bus.imem_we    = wr_fire;
        bus.imem_wdata = wr_fire ? head_instr : '0;
        bus.imem_addr  = '0;
        bus.core_instr = NOP_W;
        bus.core_stall = bus.core_req;
        if (wr_fire)
            bus.imem_addr = head_addr[IMEM_AW-1:2];
        else if (in_run)
            bus.imem_addr = bus.core_addr[IMEM_AW-1:2];
        if (in_run && !wr_fire) begin
            bus.core_instr = bus.imem_rdata;
            bus.core_stall = 1'b0;
        end
    end

    // Reset is derived straight from the state so it follows rst_i asynchronously.
    assign core_rst_o    = !in_run;
    assign load_active_o = !in_run;

`ifdef AS_IMEM_WRCOUNT_EN
    logic [15:0] wr_count_reg;
    logic        err_reg;
    logic        unused_bits;

    // Saturating write counter and sticky misaligned-write flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_count_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (wr_fire && (wr_count_reg != 16'hFFFF))
                wr_count_reg <= wr_count_reg + 1'b1;
            if (misaligned_drop)
                err_reg <= 1'b1;
        end
    end

    assign wr_count_o  = wr_count_reg;
    assign err_o       = err_reg;
    assign unused_bits = ^bus.core_addr[1:0];
`else
    logic unused_bits;

    assign wr_count_o  = '0;
    assign err_o       = 1'b0;
    assign unused_bits = ^{bus.core_addr[1:0], misaligned_drop};
`endif

endmodule

// File: tb/tb_as_imem_ctrl.sv
// tb_as_imem_ctrl: directed vectors for as_imem_ctrl plus hand sequences for
// backpressure during the release hold and reset in the middle of a stream.
`timescale 1ns/1ps
module tb_as_imem_ctrl;
    import as_pack::*;

    localparam int IMEM_AW     = 12;
    localparam int INSTR_W     = 32;
    localparam int FIFO_DEPTH  = 4;
    localparam int HOLD_CYCLES = 16;
    localparam int SW_W        = IMEM_AW + INSTR_W + 1;

`ifdef AS_IMEM_WRCOUNT_EN
    localparam bit WC_EN = 1'b1;
`else
    localparam bit WC_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        core_rst_o, load_active_o, err_o;
    logic [15:0] wr_count_o;

    as_imem_ctrl_if #(.IMEM_AW(IMEM_AW), .INSTR_W(INSTR_W)) bus ();

    as_imem_ctrl #(
        .IMEM_AW     (IMEM_AW),
        .INSTR_W     (INSTR_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bus           (bus),
        .core_rst_o    (core_rst_o),
        .load_active_o (load_active_o),
        .err_o         (err_o),
        .wr_count_o    (wr_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic               sv;
        logic [SW_W-1:0]    sw;
        logic               creq;
        logic [IMEM_AW-1:0] caddr;
        logic [INSTR_W-1:0] rdata;
        logic               e_ready;
        logic               e_we;
        logic               e_chk_addr;
        logic [IMEM_AW-3:0] e_addr;
        logic [INSTR_W-1:0] e_wdata;
        logic               e_stall;
        logic [INSTR_W-1:0] e_instr;
        logic               e_rst;
        logic               e_err;
        logic [15:0]        e_wrc;
    } vec_t;

    vec_t vq[$];
    int   n_vec       = 0;
    int   miscompares = 0;

    logic [SW_W-1:0] w1, w2, rw, wf, wm, wb, wg;
    logic [SW_W-1:0] bp_words [6];
    logic [SW_W-1:0] dw0, dw1;

    function automatic logic [SW_W-1:0] mk(input logic [IMEM_AW-1:0] a,
                                           input logic [INSTR_W-1:0] d,
                                           input logic we);
        imem_scan_word_t w;
        w.addr  = a;
        w.instr = d;
        w.we    = we;
        return w;
    endfunction

    function automatic logic [15:0] ewc(input int n);
        return WC_EN ? 16'(n) : 16'd0;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic hchk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        chk(nm, idx, act, exp);
        $display("check %s[%0d] got %h want %h", nm, idx, act, exp);
    endtask

    task automatic add_vec(input logic sv, input logic [SW_W-1:0] sw, input logic creq,
                           input logic [IMEM_AW-1:0] caddr, input logic [INSTR_W-1:0] rdata,
                           input logic e_ready, input logic e_we, input logic e_chk_addr,
                           input logic [IMEM_AW-3:0] e_addr, input logic [INSTR_W-1:0] e_wdata,
                           input logic e_stall, input logic [INSTR_W-1:0] e_instr,
                           input logic e_rst, input logic e_err, input logic [15:0] e_wrc);
        vec_t v;
        v.sv = sv; v.sw = sw; v.creq = creq; v.caddr = caddr; v.rdata = rdata;
        v.e_ready = e_ready; v.e_we = e_we; v.e_chk_addr = e_chk_addr; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_stall = e_stall; v.e_instr = e_instr; v.e_rst = e_rst;
        v.e_err = e_err; v.e_wrc = e_wrc;
        vq.push_back(v);
    endtask

    // Each vector is one clock cycle: drive, settle, compare, then advance.
    task automatic run_vecs(input int base);
        foreach (vq[i]) begin
            bus.scan_valid = vq[i].sv;
            bus.scan_word  = vq[i].sw;
            bus.core_req   = vq[i].creq;
            bus.core_addr  = vq[i].caddr;
            bus.imem_rdata = vq[i].rdata;
            #1;
            n_vec++;
            chk("scan_ready", base + i, 32'(bus.scan_ready), 32'(vq[i].e_ready));
            chk("imem_we", base + i, 32'(bus.imem_we), 32'(vq[i].e_we));
            if (vq[i].e_chk_addr)
                chk("imem_addr", base + i, 32'(bus.imem_addr), 32'(vq[i].e_addr));
            chk("imem_wdata", base + i, bus.imem_wdata, vq[i].e_wdata);
            chk("core_stall", base + i, 32'(bus.core_stall), 32'(vq[i].e_stall));
            chk("core_instr", base + i, bus.core_instr, vq[i].e_instr);
            chk("core_rst", base + i, 32'(core_rst_o), 32'(vq[i].e_rst));
            chk("load_active", base + i, 32'(load_active_o), 32'(vq[i].e_rst));
            chk("err", base + i, 32'(err_o), 32'(vq[i].e_err));
            chk("wr_count", base + i, 32'(wr_count_o), 32'(vq[i].e_wrc));
            $display("vec %0d: sv=%b word=%h req=%b we=%b addr=%h wdata=%h stall=%b instr=%h rst=%b err=%b wrc=%0d",
                     base + i, vq[i].sv, vq[i].sw, vq[i].creq, bus.imem_we, bus.imem_addr,
                     bus.imem_wdata, bus.core_stall, bus.core_instr, core_rst_o, err_o, wr_count_o);
            @(posedge clk_i); #1;
        end
        vq.delete();
    endtask

    task automatic idle_inputs();
        bus.scan_valid = 1'b0;
        bus.scan_word  = '0;
        bus.core_req   = 1'b0;
        bus.core_addr  = '0;
        bus.imem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed, nw, early, cyc, post;

        w1 = mk(12'hFF0, 32'hAAAAAAAA, 1'b1);
        w2 = mk(12'hFF4, 32'h55555555, 1'b1);
        rw = mk(12'h000, 32'h0, 1'b0);
        wf = mk(12'h010, 32'hCAFEF00D, 1'b1);
        wm = mk(12'h006, 32'hBAD0BAD0, 1'b1);
        wb = mk(12'h002, 32'h12345678, 1'b1);
        wg = mk(12'h020, 32'h00001111, 1'b1);
        for (int i = 0; i < 6; i++)
            bp_words[i] = mk(12'(12'h100 + 4 * i), 32'hC0DE0000 + 32'(i), 1'b1);
        dw0 = mk(12'h140, 32'hD0D00000, 1'b1);
        dw1 = mk(12'h144, 32'hD0D00001, 1'b1);

        // ---- reset values, with a scan word offered while reset is held ----
        idle_inputs();
        bus.scan_valid = 1'b1;
        bus.scan_word  = w1;
        rst_i = 1'b0;
        #2;
        hchk("rst_scan_ready", 0, 32'(bus.scan_ready), 32'd1);
        hchk("rst_core_rst", 0, 32'(core_rst_o), 32'd1);
        hchk("rst_load_active", 0, 32'(load_active_o), 32'd1);
        hchk("rst_core_stall", 0, 32'(bus.core_stall), 32'd0);
        hchk("rst_imem_we", 0, 32'(bus.imem_we), 32'd0);
        hchk("rst_imem_addr", 0, 32'(bus.imem_addr), 32'd0);
        hchk("rst_imem_wdata", 0, bus.imem_wdata, 32'd0);
        hchk("rst_core_instr", 0, bus.core_instr, NOP_INSTR);
        hchk("rst_err", 0, 32'(err_o), 32'd0);
        hchk("rst_wr_count", 0, 32'(wr_count_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        hchk("rst_scan_ready_held", 1, 32'(bus.scan_ready), 32'd1);
        hchk("rst_imem_we_held", 1, 32'(bus.imem_we), 32'd0);
        idle_inputs();
        rst_i = 1'b1;

        // ---- load two writes, release, hold, run, fetch vs late write ----
        add_vec(1, w1, 0, 12'h000, 32'h0, 1, 0, 0, 10'h000, 32'h0, 0, NOP_INSTR, 1, 0, 16'd0);
        add_vec(1, w2, 0, 12'h000, 32'h0, 1, 1, 1, 10'h3FC, 32'hAAAAAAAA, 0, NOP_INSTR, 1, 0, 16'd0);
        add_vec(1, rw, 0, 12'h000, 32'h0, 1, 1, 1, 10'h3FD, 32'h55555555, 0, NOP_INSTR, 1, 0, ewc(1));
        // release word popped here (cycle M); core stays in reset and stalled
        add_vec(0, '0, 1, 12'h040, 32'hDEADBEEF, 1, 0, 0, 10'h000, 32'h0, 1, NOP_INSTR, 1, 0, ewc(2));
        for (int k = 1; k < HOLD_CYCLES; k++)
            add_vec(0, '0, 1, 12'h040, 32'hDEADBEEF, 1, 0, 0, 10'h000, 32'h0, 1, NOP_INSTR, 1, 0, ewc(2));
        // cycle M+HOLD_CYCLES: core out of reset, zero-latency fetch
        add_vec(0, '0, 1, 12'h040, 32'hDEADBEEF, 1, 0, 1, 10'h010, 32'h0, 0, 32'hDEADBEEF, 0, 0, ewc(2));
        add_vec(1, wf, 1, 12'h040, 32'hDEADBEEF, 1, 0, 1, 10'h010, 32'h0, 0, 32'hDEADBEEF, 0, 0, ewc(2));
        add_vec(0, '0, 1, 12'h040, 32'hDEADBEEF, 1, 1, 1, 10'h004, 32'hCAFEF00D, 1, NOP_INSTR, 0, 0, ewc(2));
        add_vec(0, '0, 1, 12'h07C, 32'h12345678, 1, 0, 1, 10'h01F, 32'h0, 0, 32'h12345678, 0, 0, ewc(3));
        // misaligned write in RUN: dropped, core keeps fetching
        add_vec(1, wm, 1, 12'h07C, 32'h12345678, 1, 0, 1, 10'h01F, 32'h0, 0, 32'h12345678, 0, 0, ewc(3));
        add_vec(0, '0, 1, 12'h07C, 32'h12345678, 1, 0, 1, 10'h01F, 32'h0, 0, 32'h12345678, 0, 0, ewc(3));
        add_vec(0, '0, 0, 12'h07C, 32'h12345678, 1, 0, 1, 10'h01F, 32'h0, 0, 32'h12345678, 0, WC_EN, ewc(3));
        // release word in RUN: ignored
        add_vec(1, rw, 0, 12'h07C, 32'h12345678, 1, 0, 1, 10'h01F, 32'h0, 0, 32'h12345678, 0, WC_EN, ewc(3));
        add_vec(0, '0, 0, 12'h07C, 32'h12345678, 1, 0, 1, 10'h01F, 32'h0, 0, 32'h12345678, 0, WC_EN, ewc(3));
        add_vec(0, '0, 0, 12'h07C, 32'h12345678, 1, 0, 1, 10'h01F, 32'h0, 0, 32'h12345678, 0, WC_EN, ewc(3));
        run_vecs(100);

        // ---- misaligned write in LOAD ----
        do_reset();
        add_vec(1, wb, 0, 12'h000, 32'h0, 1, 0, 0, 10'h000, 32'h0, 0, NOP_INSTR, 1, 0, 16'd0);
        add_vec(0, '0, 0, 12'h000, 32'h0, 1, 0, 0, 10'h000, 32'h0, 0, NOP_INSTR, 1, 0, 16'd0);
        add_vec(0, '0, 0, 12'h000, 32'h0, 1, 0, 0, 10'h000, 32'h0, 0, NOP_INSTR, 1, WC_EN, 16'd0);
        add_vec(1, wg, 0, 12'h000, 32'h0, 1, 0, 0, 10'h000, 32'h0, 0, NOP_INSTR, 1, WC_EN, 16'd0);
        add_vec(0, '0, 0, 12'h000, 32'h0, 1, 1, 1, 10'h008, 32'h00001111, 0, NOP_INSTR, 1, WC_EN, 16'd0);
        add_vec(0, '0, 0, 12'h000, 32'h0, 1, 0, 0, 10'h000, 32'h0, 0, NOP_INSTR, 1, WC_EN, ewc(1));
        run_vecs(200);

        // ---- backpressure while a release hold is running ----
        do_reset();
        bus.scan_valid = 1'b1;
        bus.scan_word  = rw;
        @(posedge clk_i); #1;          // cycle M: release at head, popped now
        bus.scan_valid = 1'b0;
        @(posedge clk_i); #1;          // cycle M+1: RELEASE
        pushed = 0; nw = 0; early = 0; cyc = 1;
        while (nw < 6 && cyc < 80) begin
            bus.scan_valid = (pushed < 6);
            bus.scan_word  = bp_words[(pushed < 6) ? pushed : 5];
            #1;
            if (bus.imem_we) begin
                if (load_active_o) begin
                    early++;
                end else begin
                    hchk("bp_addr", nw, 32'(bus.imem_addr), 32'h40 + 32'(nw));
                    hchk("bp_data", nw, bus.imem_wdata, 32'hC0DE0000 + 32'(nw));
                    nw++;
                end
            end
            if (cyc == 10) begin
                hchk("bp_ready_full", cyc, 32'(bus.scan_ready), 32'd0);
                hchk("bp_pushed", cyc, 32'(pushed), 32'd4);
            end
            if (cyc == HOLD_CYCLES - 1)
                hchk("bp_core_rst_hold", cyc, 32'(core_rst_o), 32'd1);
            if (cyc == HOLD_CYCLES)
                hchk("bp_core_rst_drop", cyc, 32'(core_rst_o), 32'd0);
            if (bus.scan_valid && bus.scan_ready)
                pushed++;
            @(posedge clk_i); #1;
            cyc++;
        end
        bus.scan_valid = 1'b0;
        hchk("bp_writes", cyc, 32'(nw), 32'd6);
        hchk("bp_early_writes", cyc, 32'(early), 32'd0);

        // ---- reset mid-stream, in RUN, after 2 of 4 pushes ----
        bus.scan_valid = 1'b1;
        bus.scan_word  = dw0;
        @(posedge clk_i); #1;
        #1;
        hchk("mid_we_first", 0, 32'(bus.imem_we), 32'd1);
        hchk("mid_addr_first", 0, 32'(bus.imem_addr), 32'h050);
        bus.scan_word = dw1;
        @(posedge clk_i); #1;
        bus.scan_valid = 1'b0;
        rst_i = 1'b0;
        #1;
        hchk("mid_core_rst", 1, 32'(core_rst_o), 32'd1);
        hchk("mid_load_active", 1, 32'(load_active_o), 32'd1);
        hchk("mid_imem_we", 1, 32'(bus.imem_we), 32'd0);
        hchk("mid_scan_ready", 1, 32'(bus.scan_ready), 32'd1);
        hchk("mid_wr_count", 1, 32'(wr_count_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        post = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.imem_we) post++;
            @(posedge clk_i); #1;
        end
        hchk("mid_post_writes", 2, 32'(post), 32'd0);
        hchk("mid_core_rst_after", 2, 32'(core_rst_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
